// File: rtl/stoch_to_bin.sv
// Counts the ones in a unipolar stochastic bitstream over a window of 2**WIDTH
// accepted samples and publishes the total on `value` with a one-cycle `done` pulse.
module stoch_to_bin #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH:0]   RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             x,
    input  logic             in_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   value
);

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   scnt;
    logic [WIDTH:0]     acc;
    logic [WIDTH:0]     acc_next;
    logic               last_sample;

    // acc is one bit wider than scnt so an all-ones window reaches 2**WIDTH exactly.
    assign acc_next    = acc + (WIDTH+1)'(x);
    assign last_sample = (scnt == '1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            scnt  <= '0;
            acc   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            value <= RESET_VALUE;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // x on the start cycle is deliberately not sampled.
                    if (start) begin
                        state <= COUNT;
                        busy  <= 1'b1;
                        scnt  <= '0;
                        acc   <= '0;
                    end
                end
                COUNT: begin
                    if (in_valid) begin
                        acc  <= acc_next;
                        scnt <= scnt + WIDTH'(1);
                        if (last_sample) begin
                            value <= acc_next;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stoch_to_bin.sv
// Directed bench for stoch_to_bin: a WIDTH=4 instance for the window/handshake cases
// and a WIDTH=8 instance fed from an LFSR with a bench-computed popcount.
module tb_stoch_to_bin;

    logic       clk = 1'b0;
    logic       rst;
    logic       start4, x4, v4, busy4, done4;
    logic [4:0] value4;
    logic       start8, x8, v8, busy8, done8;
    logic [8:0] value8;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    stoch_to_bin #(.WIDTH(4), .RESET_VALUE(5'd0)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .x(x4), .in_valid(v4),
        .busy(busy4), .done(done4), .value(value4)
    );

    stoch_to_bin #(.WIDTH(8), .RESET_VALUE(9'd0)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .x(x8), .in_valid(v8),
        .busy(busy8), .done(done8), .value(value8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start, then feed 16 samples (bits[0] first); optional invalid cycle before each.
    // Returns edges from the start edge (counted as 1) to the edge that raised done.
    task automatic feed4(input logic [15:0] bits, input bit gaps, input bit junk_x,
                         output int cyc, output logic [4:0] val, output logic bsy);
        int  i;
        bit  phase;
        bit  got;
        start4 = 1'b1; v4 = 1'b1; x4 = 1'b1;
        step();
        start4 = 1'b0;
        cyc = 1; i = 0; phase = 1'b0; got = 1'b0;
        val = 'x; bsy = 1'bx;
        while (!got && cyc < 100) begin
            if (gaps && !phase) begin
                v4 = 1'b0; x4 = junk_x;
            end else if (i < 16) begin
                v4 = 1'b1; x4 = bits[i]; i++;
            end else begin
                v4 = 1'b0; x4 = 1'b0;
            end
            phase = ~phase;
            step();
            cyc++;
            if (done4 === 1'b1) begin
                got = 1'b1; val = value4; bsy = busy4;
            end
        end
        v4 = 1'b0; x4 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start4 = 1'b0; x4 = 1'b0; v4 = 1'b0;
        start8 = 1'b0; x8 = 1'b0; v8 = 1'b0;
        #2;
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL reset_busy4 got %b want 0", busy4); end
        n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL reset_done4 got %b want 0", done4); end
        n_cmp++; if (value4 !== 5'd0) begin n_bad++; $display("FAIL reset_value4 got %0d want 0", value4); end
        n_cmp++; if (value8 !== 9'd0) begin n_bad++; $display("FAIL reset_value8 got %0d want 0", value8); end
        step(); step();
        rst = 1'b0;
        step();
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL idle_busy4 got %b want 0", busy4); end
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL idle_busy8 got %b want 0", busy8); end
    endtask

    task automatic test_all_ones();
        int cyc; logic [4:0] val; logic bsy;
        feed4(16'hFFFF, 1'b0, 1'b0, cyc, val, bsy);
        n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL ones_latency got %0d want 17", cyc); end
        n_cmp++; if (val !== 5'd16) begin n_bad++; $display("FAIL ones_value got %0d want 16", val); end
        n_cmp++; if (bsy !== 1'b0) begin n_bad++; $display("FAIL ones_busy_at_done got %b want 0", bsy); end
        step();
        n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL ones_done_pulse got %b want 0", done4); end
        n_cmp++; if (value4 !== 5'd16) begin n_bad++; $display("FAIL ones_value_hold got %0d want 16", value4); end
    endtask

    task automatic test_patterns();
        int cyc; logic [4:0] val; logic bsy;
        feed4(16'h0000, 1'b0, 1'b0, cyc, val, bsy);
        n_cmp++; if (val !== 5'd0) begin n_bad++; $display("FAIL zeros_value got %0d want 0", val); end
        n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL zeros_latency got %0d want 17", cyc); end
        step();
        feed4(16'h5555, 1'b0, 1'b0, cyc, val, bsy);
        n_cmp++; if (val !== 5'd8) begin n_bad++; $display("FAIL alt_value got %0d want 8", val); end
        n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL alt_latency got %0d want 17", cyc); end
        step();
        feed4(16'h0007, 1'b0, 1'b0, cyc, val, bsy);
        n_cmp++; if (val !== 5'd3) begin n_bad++; $display("FAIL three_value got %0d want 3", val); end
        n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL three_latency got %0d want 17", cyc); end
        step();
    endtask

    task automatic test_gaps();
        int cyc; logic [4:0] val; logic bsy;
        // x=1 on every invalid cycle must be ignored.
        feed4(16'hFFFF, 1'b1, 1'b1, cyc, val, bsy);
        n_cmp++; if (cyc !== 33) begin n_bad++; $display("FAIL gaps_latency got %0d want 33", cyc); end
        n_cmp++; if (val !== 5'd16) begin n_bad++; $display("FAIL gaps_value got %0d want 16", val); end
        step();
        feed4(16'h0000, 1'b1, 1'b1, cyc, val, bsy);
        n_cmp++; if (val !== 5'd0) begin n_bad++; $display("FAIL gaps_junk_value got %0d want 0", val); end
        step();
    endtask

    task automatic test_back_to_back();
        int  cyc;
        int  k;
        bit  got;
        start4 = 1'b1; v4 = 1'b0;
        step();
        start4 = 1'b0;
        cyc = 1; k = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            v4 = (k < 16); x4 = 1'b1;
            start4 = (k == 5);
            k++;
            step();
            cyc++;
            if (done4 === 1'b1) got = 1'b1;
        end
        n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL restart_ignored_latency got %0d want 17", cyc); end
        n_cmp++; if (value4 !== 5'd16) begin n_bad++; $display("FAIL restart_ignored_value got %0d want 16", value4); end
        // start presented in the done cycle is accepted
        start4 = 1'b1; v4 = 1'b0; x4 = 1'b0;
        step();
        start4 = 1'b0;
        n_cmp++; if (busy4 !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got %b want 1", busy4); end
        cyc = 1; k = 0; got = 1'b0;
        while (!got && cyc < 100) begin
            v4 = (k < 16); x4 = (k % 2 == 0);
            k++;
            step();
            cyc++;
            if (done4 === 1'b1) got = 1'b1;
        end
        v4 = 1'b0; x4 = 1'b0;
        n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL b2b_latency got %0d want 17", cyc); end
        n_cmp++; if (value4 !== 5'd8) begin n_bad++; $display("FAIL b2b_value got %0d want 8", value4); end
        step();
    endtask

    task automatic test_async_reset();
        int cyc; logic [4:0] val; logic bsy;
        start4 = 1'b1; v4 = 1'b0;
        step();
        start4 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            v4 = 1'b1; x4 = 1'b1;
            step();
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (busy4 !== 1'b0) begin n_bad++; $display("FAIL arst_busy got %b want 0", busy4); end
        n_cmp++; if (done4 !== 1'b0) begin n_bad++; $display("FAIL arst_done got %b want 0", done4); end
        n_cmp++; if (value4 !== 5'd0) begin n_bad++; $display("FAIL arst_value got %0d want 0 (was 8)", value4); end
        v4 = 1'b0; x4 = 1'b0;
        #1 rst = 1'b0;
        step();
        feed4(16'h0007, 1'b0, 1'b0, cyc, val, bsy);
        n_cmp++; if (val !== 5'd3) begin n_bad++; $display("FAIL arst_fresh_value got %0d want 3", val); end
        n_cmp++; if (cyc !== 17) begin n_bad++; $display("FAIL arst_fresh_latency got %0d want 17", cyc); end
        step();
    endtask

    task automatic test_lfsr_w8();
        logic [15:0] lfsr;
        int          expect_cnt;
        int          cyc;
        int          k;
        bit          got;
        lfsr = 16'hACE1;
        expect_cnt = 0;
        start8 = 1'b1; v8 = 1'b0;
        step();
        start8 = 1'b0;
        cyc = 1; k = 0; got = 1'b0;
        while (!got && cyc < 400) begin
            if (k < 256) begin
                v8 = 1'b1;
                x8 = lfsr[0] & lfsr[1];
                if (x8) expect_cnt++;
                lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            end else begin
                v8 = 1'b0; x8 = 1'b0;
            end
            k++;
            step();
            cyc++;
            if (done8 === 1'b1) got = 1'b1;
        end
        v8 = 1'b0; x8 = 1'b0;
        n_cmp++; if (cyc !== 257) begin n_bad++; $display("FAIL w8_latency got %0d want 257", cyc); end
        n_cmp++; if (value8 !== 9'(expect_cnt)) begin n_bad++; $display("FAIL w8_popcount got %0d want %0d", value8, expect_cnt); end
        n_cmp++; if (busy8 !== 1'b0) begin n_bad++; $display("FAIL w8_busy_at_done got %b want 0", busy8); end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_patterns();
        test_gaps();
        test_back_to_back();
        test_async_reset();
        test_lfsr_w8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
